mux2_arb: RTL

MUX2_ARB -- requirements
Module: mux2_arb

---
 rtl/mux2_arb.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mux2_arb.sv
// mux2_arb: two-requester burst arbiter feeding a registered mux2 output.
// Optional MUX2_ARB_HOLD_LIMIT_EN caps each grant at MAX_HOLD beats.
module mux2_arb #(
  parameter int WIDTH    = 8,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       in_valid,
  input  logic [1:0]       in_last,
  input  logic [WIDTH-1:0] in_data0,
  input  logic [WIDTH-1:0] in_data1,
  output logic [1:0]       in_ready,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE,
    GRANT0,
    GRANT1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic             ptr;
  logic             can_load;
  logic             xfer;
  logic             xfer_last;
  logic [WIDTH-1:0] xfer_data;
  logic             hold_hit;
  logic             release_g;

  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("mux2_arb: MAX_HOLD must be 1..255");
  end

  // handshake and datapath selection follow the grant state
  always_comb begin
    can_load    = !out_valid || out_ready;
    in_ready[0] = (state == GRANT0) && can_load;
    in_ready[1] = (state == GRANT1) && can_load;
    sel         = (state == GRANT1);
    xfer        = |(in_valid & in_ready);
    xfer_last   = sel ? in_last[1] : in_last[0];
    xfer_data   = sel ? in_data1 : in_data0;
    release_g   = xfer && (xfer_last || hold_hit);
  end

`ifdef MUX2_ARB_HOLD_LIMIT_EN
  logic [7:0] beat_cnt;

  assign hold_hit = (beat_cnt == 8'(MAX_HOLD - 1));

  // beats taken under the current grant; zero while idle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      beat_cnt <= '0;
    end else if (xfer) begin
      beat_cnt <= release_g ? 8'd0 : beat_cnt + 8'd1;
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  // grant state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // grant decisions; a grant stays locked until its release beat
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (in_valid)
          2'b01:   state_nxt = GRANT0;
          2'b10:   state_nxt = GRANT1;
          2'b11:   state_nxt = ptr ? GRANT1 : GRANT0;
          default: state_nxt = IDLE;
        endcase
      end
      GRANT0, GRANT1: begin
        if (release_g) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // preference passes to the other requester when a grant ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (release_g) begin
      ptr <= ~sel;
    end
  end

  // output beat register; new beat may replace one draining this cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= xfer_data;
      out_last  <= xfer_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
